// File: rtl/add_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one add_process meta/data port among reth, aeth and raw.
// Define ADD_ARB_STATS_EN to add per-source packet counters and a forwarded-beat counter.
module add_stream_arbiter #(
    parameter int DATA_W = 512,
    parameter int META_W = 88
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_reth_meta_in_valid,
    output logic                  io_reth_meta_in_ready,
    input  logic [META_W-1:0]     io_reth_meta_in_bits,
    input  logic                  io_reth_data_in_valid,
    output logic                  io_reth_data_in_ready,
    input  logic                  io_reth_data_in_bits_last,
    input  logic [DATA_W-1:0]     io_reth_data_in_bits_data,
    input  logic [DATA_W/8-1:0]   io_reth_data_in_bits_keep,
    input  logic                  io_aeth_meta_in_valid,
    output logic                  io_aeth_meta_in_ready,
    input  logic [META_W-1:0]     io_aeth_meta_in_bits,
    input  logic                  io_aeth_data_in_valid,
    output logic                  io_aeth_data_in_ready,
    input  logic                  io_aeth_data_in_bits_last,
    input  logic [DATA_W-1:0]     io_aeth_data_in_bits_data,
    input  logic [DATA_W/8-1:0]   io_aeth_data_in_bits_keep,
    input  logic                  io_raw_meta_in_valid,
    output logic                  io_raw_meta_in_ready,
    input  logic [META_W-1:0]     io_raw_meta_in_bits,
    input  logic                  io_raw_data_in_valid,
    output logic                  io_raw_data_in_ready,
    input  logic                  io_raw_data_in_bits_last,
    input  logic [DATA_W-1:0]     io_raw_data_in_bits_data,
    input  logic [DATA_W/8-1:0]   io_raw_data_in_bits_keep,
    output logic                  io_meta_out_valid,
    input  logic                  io_meta_out_ready,
    output logic [META_W-1:0]     io_meta_out_bits,
    output logic [1:0]            io_meta_out_src,
    output logic                  io_data_out_valid,
    input  logic                  io_data_out_ready,
    output logic                  io_data_out_bits_last,
    output logic [DATA_W-1:0]     io_data_out_bits_data,
    output logic [DATA_W/8-1:0]   io_data_out_bits_keep,
`ifdef ADD_ARB_STATS_EN
    output logic [31:0]           io_pkt_cnt_reth,
    output logic [31:0]           io_pkt_cnt_aeth,
    output logic [31:0]           io_pkt_cnt_raw,
    output logic [31:0]           io_beat_cnt,
`endif
    output logic                  io_busy
);
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, META, DATA} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;

    // Requester inputs gathered into arrays indexed by source id (0=reth, 1=aeth, 2=raw).
    logic [2:0]              meta_vld, data_vld, data_last;
    logic [META_W-1:0]       meta_bits [3];
    logic [DATA_W-1:0]       data_bits [3];
    logic [KEEP_W-1:0]       keep_bits [3];
    logic [2:0]              meta_rdy, data_rdy;

    assign meta_vld  = {io_raw_meta_in_valid, io_aeth_meta_in_valid, io_reth_meta_in_valid};
    assign data_vld  = {io_raw_data_in_valid, io_aeth_data_in_valid, io_reth_data_in_valid};
    assign data_last = {io_raw_data_in_bits_last, io_aeth_data_in_bits_last, io_reth_data_in_bits_last};
    assign meta_bits[0] = io_reth_meta_in_bits;
    assign meta_bits[1] = io_aeth_meta_in_bits;
    assign meta_bits[2] = io_raw_meta_in_bits;
    assign data_bits[0] = io_reth_data_in_bits_data;
    assign data_bits[1] = io_aeth_data_in_bits_data;
    assign data_bits[2] = io_raw_data_in_bits_data;
    assign keep_bits[0] = io_reth_data_in_bits_keep;
    assign keep_bits[1] = io_aeth_data_in_bits_keep;
    assign keep_bits[2] = io_raw_data_in_bits_keep;

    function automatic logic [1:0] rr_next(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return 2'(s % 3);
    endfunction

    // Scan from farthest to nearest so the nearest valid requester after last_grant wins.
    logic [1:0] rr_pick;
    always_comb begin
        rr_pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (meta_vld[rr_next(last_grant_q, k)]) rr_pick = rr_next(last_grant_q, k);
        end
    end

    logic meta_hs, data_hs;
    assign meta_hs = io_meta_out_valid & io_meta_out_ready;
    assign data_hs = io_data_out_valid & io_data_out_ready;

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
        meta_rdy          = 3'b000;
        data_rdy          = 3'b000;
        io_meta_out_valid = 1'b0;
        io_data_out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (|meta_vld) begin
                    grant_d = rr_pick;
                    state_d = META;
                end
            end
            META: begin
                io_meta_out_valid = meta_vld[grant_q];
                meta_rdy[grant_q] = io_meta_out_ready;
                if (meta_hs) state_d = DATA;
            end
            DATA: begin
                io_data_out_valid = data_vld[grant_q];
                data_rdy[grant_q] = io_data_out_ready;
                if (data_hs && data_last[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign io_meta_out_bits      = meta_bits[grant_q];
    assign io_meta_out_src       = grant_q;
    assign io_data_out_bits_data = data_bits[grant_q];
    assign io_data_out_bits_keep = keep_bits[grant_q];
    assign io_data_out_bits_last = data_last[grant_q];
    assign io_busy               = (state_q != IDLE);

    assign io_reth_meta_in_ready = meta_rdy[0];
    assign io_aeth_meta_in_ready = meta_rdy[1];
    assign io_raw_meta_in_ready  = meta_rdy[2];
    assign io_reth_data_in_ready = data_rdy[0];
    assign io_aeth_data_in_ready = data_rdy[1];
    assign io_raw_data_in_ready  = data_rdy[2];

`ifdef ADD_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [3];
    logic [31:0] pkt_cnt_d [3];
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q + {31'd0, data_hs};
        for (int i = 0; i < 3; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (data_hs && io_data_out_bits_last && (int'(grant_q) == i))
                pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beat_cnt_q <= 32'd0;
            for (int i = 0; i < 3; i++) pkt_cnt_q[i] <= 32'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            for (int i = 0; i < 3; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
        end
    end

    assign io_pkt_cnt_reth = pkt_cnt_q[0];
    assign io_pkt_cnt_aeth = pkt_cnt_q[1];
    assign io_pkt_cnt_raw  = pkt_cnt_q[2];
    assign io_beat_cnt     = beat_cnt_q;
`endif

endmodule

// File: tb/tb_add_stream_arbiter.sv
// Directed bench for add_stream_arbiter: packet-queue sources, an ownership-level reference model
// checked every cycle, and hand-computed grant-order / beat-order expectations per scenario.
module tb_add_stream_arbiter;
    localparam int DW = 512;
    localparam int MW = 88;
    localparam int KW = DW / 8;

    typedef struct {
        logic [MW-1:0] meta;
        int            beats;
        int            base;
    } pkt_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0]    mv, dv, dl;
    logic [MW-1:0] mb [3];
    logic [DW-1:0] db [3];
    logic [KW-1:0] kb [3];
    logic          mo_rdy, do_rdy;
    wire  [2:0]    mr, dr;
    wire           mov, dov, dol, busy;
    wire  [MW-1:0] mob;
    wire  [1:0]    src;
    wire  [DW-1:0] dob;
    wire  [KW-1:0] dok;
`ifdef ADD_ARB_STATS_EN
    wire  [31:0]   pc_reth, pc_aeth, pc_raw, bc;
`endif

    add_stream_arbiter #(.DATA_W(DW), .META_W(MW)) dut (
        .clock(clock), .reset(reset),
        .io_reth_meta_in_valid(mv[0]), .io_reth_meta_in_ready(mr[0]), .io_reth_meta_in_bits(mb[0]),
        .io_reth_data_in_valid(dv[0]), .io_reth_data_in_ready(dr[0]), .io_reth_data_in_bits_last(dl[0]),
        .io_reth_data_in_bits_data(db[0]), .io_reth_data_in_bits_keep(kb[0]),
        .io_aeth_meta_in_valid(mv[1]), .io_aeth_meta_in_ready(mr[1]), .io_aeth_meta_in_bits(mb[1]),
        .io_aeth_data_in_valid(dv[1]), .io_aeth_data_in_ready(dr[1]), .io_aeth_data_in_bits_last(dl[1]),
        .io_aeth_data_in_bits_data(db[1]), .io_aeth_data_in_bits_keep(kb[1]),
        .io_raw_meta_in_valid(mv[2]), .io_raw_meta_in_ready(mr[2]), .io_raw_meta_in_bits(mb[2]),
        .io_raw_data_in_valid(dv[2]), .io_raw_data_in_ready(dr[2]), .io_raw_data_in_bits_last(dl[2]),
        .io_raw_data_in_bits_data(db[2]), .io_raw_data_in_bits_keep(kb[2]),
        .io_meta_out_valid(mov), .io_meta_out_ready(mo_rdy), .io_meta_out_bits(mob), .io_meta_out_src(src),
        .io_data_out_valid(dov), .io_data_out_ready(do_rdy), .io_data_out_bits_last(dol),
        .io_data_out_bits_data(dob), .io_data_out_bits_keep(dok),
`ifdef ADD_ARB_STATS_EN
        .io_pkt_cnt_reth(pc_reth), .io_pkt_cnt_aeth(pc_aeth), .io_pkt_cnt_raw(pc_raw), .io_beat_cnt(bc),
`endif
        .io_busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Source-side state: queued packets, and per source whether its meta went out and which beat is next.
    pkt_t pq [3][$];
    bit   phase [3];
    int   beat [3];
    bit   hs_m [3];
    bit   hs_d [3];
    logic [2:0] meta_en = 3'b111;
    logic [2:0] data_en = 3'b111;

    // Reference: who owns the port, whether its meta was delivered, who was served last.
    int m_owner = -1;
    bit m_msent = 1'b0;
    int m_last = 2;
    int m_pkt [3];
    int m_beats = 0;

    int src_log[$];
    int beat_log[$];
    int mov_cyc = -1;
    logic [MW-1:0] mov_bits = '0;

    function automatic logic [DW-1:0] beat_data(input int v);
        return {16{32'(v)}};
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int v);
        return {32'(v), ~32'(v)};
    endfunction

    task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (pq[i].size() > 0) begin
                mv[i] = meta_en[i] && !phase[i];
                dv[i] = data_en[i];
                dl[i] = (beat[i] == pq[i][0].beats - 1);
                mb[i] = pq[i][0].meta;
                db[i] = beat_data(pq[i][0].base + beat[i]);
                kb[i] = beat_keep(pq[i][0].base + beat[i]);
            end else begin
                mv[i] = 1'b0; dv[i] = 1'b0; dl[i] = 1'b0;
                mb[i] = '0;   db[i] = '0;   kb[i] = '0;
            end
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= 3; k++) begin
            if (mv[(m_last + k) % 3]) return (m_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_update();
        if (m_owner < 0) begin
            if (|mv) m_owner = rr_pick();
        end else if (!m_msent) begin
            if (mv[m_owner] && mo_rdy) m_msent = 1'b1;
        end else if (dv[m_owner] && do_rdy) begin
            m_beats++;
            if (dl[m_owner]) begin
                m_pkt[m_owner]++;
                m_last  = m_owner;
                m_owner = -1;
                m_msent = 1'b0;
            end
        end
    endtask

    task automatic check();
        logic [2:0] emr, edr;
        bit emov, edov;
        if (!reset) begin
            cmp("rst_busy", busy, 0);
            cmp("rst_meta_valid", mov, 0);
            cmp("rst_data_valid", dov, 0);
            cmp("rst_meta_ready", mr, 0);
            cmp("rst_data_ready", dr, 0);
            cmp("rst_src", src, 0);
            m_owner = -1; m_msent = 1'b0; m_last = 2; m_beats = 0;
            for (int i = 0; i < 3; i++) begin
                m_pkt[i] = 0; pq[i].delete(); phase[i] = 1'b0; beat[i] = 0;
                hs_m[i] = 1'b0; hs_d[i] = 1'b0;
            end
            return;
        end
        emr = 3'b000; edr = 3'b000; emov = 1'b0; edov = 1'b0;
        if (m_owner >= 0) begin
            if (!m_msent) begin
                emr[m_owner] = mo_rdy;
                emov = mv[m_owner];
            end else begin
                edr[m_owner] = do_rdy;
                edov = dv[m_owner];
            end
        end
        cmp("busy", busy, m_owner >= 0);
        cmp("meta_in_ready", mr, emr);
        cmp("data_in_ready", dr, edr);
        cmp("meta_out_valid", mov, emov);
        cmp("data_out_valid", dov, edov);
        if (emov && mov) begin
            cmp("meta_out_bits", mob, pq[m_owner][0].meta);
            cmp("meta_out_src", src, m_owner);
        end
        if (edov && dov) begin
            cmp("data_out_data", dob, beat_data(pq[m_owner][0].base + beat[m_owner]));
            cmp("data_out_keep", dok, beat_keep(pq[m_owner][0].base + beat[m_owner]));
            cmp("data_out_last", dol, beat[m_owner] == pq[m_owner][0].beats - 1);
        end
`ifdef ADD_ARB_STATS_EN
        cmp("pkt_cnt_reth", pc_reth, m_pkt[0]);
        cmp("pkt_cnt_aeth", pc_aeth, m_pkt[1]);
        cmp("pkt_cnt_raw", pc_raw, m_pkt[2]);
        cmp("beat_cnt", bc, m_beats);
`endif
        if (mov && mov_cyc < 0) begin
            mov_cyc  = cyc;
            mov_bits = mob;
        end
        if (mov && mo_rdy) src_log.push_back(int'(src));
        if (dov && do_rdy) beat_log.push_back(int'(dob[31:0]));
        for (int i = 0; i < 3; i++) begin
            hs_m[i] = mv[i] && mr[i];
            hs_d[i] = dv[i] && dr[i];
        end
    endtask

    // One clock: check on the falling edge, advance the model on the rising edge, move sources just after.
    task automatic step();
        @(negedge clock);
        check();
        cyc++;
        @(posedge clock);
        if (reset) model_update();
        #1;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                if (hs_m[i]) phase[i] = 1'b1;
                if (hs_d[i] && pq[i].size() > 0) begin
                    if (beat[i] == pq[i][0].beats - 1) begin
                        void'(pq[i].pop_front());
                        beat[i]  = 0;
                        phase[i] = 1'b0;
                    end else begin
                        beat[i]++;
                    end
                end
                hs_m[i] = 1'b0;
                hs_d[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic push(input int s, input logic [MW-1:0] meta, input int beats, input int base);
        pkt_t p;
        p.meta = meta; p.beats = beats; p.base = base;
        pq[s].push_back(p);
    endtask

    task automatic drain(input string nm, input int maxc);
        int n = 0;
        while ((pq[0].size() + pq[1].size() + pq[2].size()) > 0 && n < maxc) begin
            step();
            n++;
        end
        cmp({nm, "_drained"}, n < maxc, 1);
        step();
        cmp({nm, "_busy_end"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive();
        step();
        step();
        reset = 1'b1;
        src_log.delete();
        beat_log.delete();
    endtask

    task automatic cmp_list(input string nm, input int got[$], input int exp[$]);
        cmp({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            cmp($sformatf("%s_%0d", nm, i), got[i], exp[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;
        mo_rdy = 1'b1;
        do_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin m_pkt[i] = 0; phase[i] = 0; beat[i] = 0; end
        drive();
        #1 reset = 1'b0;
        step();
        step();
        reset = 1'b1;

        // Single reth packet: meta visible on the second sampled cycle after valid rises.
        push(0, {8'h0a, 24'd1, 24'd2, 32'd64}, 1, 100);
        drive();
        c0 = cyc;
        mov_cyc = -1;
        drain("t1", 20);
        cmp("t1_meta_latency", mov_cyc - c0, 1);
        cmp("t1_meta_bits", mov_bits, 88'h0a_000001_000002_00000040);
        cmp_list("t1_src", src_log, '{0});
        cmp_list("t1_beats", beat_log, '{100});

        // Three simultaneous 2-beat requests right after reset.
        do_reset();
        push(0, 88'h11, 2, 200);
        push(1, 88'h22, 2, 300);
        push(2, 88'h33, 2, 400);
        drive();
        drain("t2", 40);
        cmp_list("t2_src", src_log, '{0, 1, 2});
        cmp_list("t2_beats", beat_log, '{200, 201, 300, 301, 400, 401});

        // Reth and raw back to back; last grant was raw, so reth leads.
        src_log.delete(); beat_log.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 88'h40 + 88'(i), 1, 1000 + i);
            push(2, 88'h50 + 88'(i), 1, 2000 + i);
        end
        drive();
        drain("t3", 60);
        cmp_list("t3_src", src_log, '{0, 2, 0, 2, 0, 2, 0, 2});

        // Aeth 3-beat packet: meta valid dropped in META, then 5 cycles of data backpressure.
        src_log.delete(); beat_log.delete();
        push(1, 88'h66, 3, 500);
        drive();
        n = 0;
        while (!(m_owner == 1 && !m_msent) && n < 10) begin step(); n++; end
        cmp("t4_reach_meta", n < 10, 1);
        meta_en[1] = 1'b0;
        drive();
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("t4_meta_stall_valid", mov, 0);
            cmp("t4_meta_stall_busy", busy, 1);
        end
        meta_en[1] = 1'b1;
        drive();
        n = 0;
        while (!(m_msent && beat[1] == 1) && n < 10) begin step(); n++; end
        cmp("t4_reach_beat1", n < 10, 1);
        do_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            cmp("t4_stall_valid", dov, 1);
            cmp("t4_stall_data", dob[31:0], 501);
            cmp("t4_stall_ready", dr[1], 0);
        end
        do_rdy = 1'b1;
        drain("t4", 20);
        cmp_list("t4_src", src_log, '{1});
        cmp_list("t4_beats", beat_log, '{500, 501, 502});

        // Reset during beat 2 of a 4-beat reth packet; afterwards reth has priority again.
        push(0, 88'h77, 4, 600);
        drive();
        n = 0;
        while (!(phase[0] && beat[0] == 1) && n < 10) begin step(); n++; end
        cmp("t5_reach_beat2", n < 10, 1);
        reset = 1'b0;
        #1;
        cmp("t5_rst_busy", busy, 0);
        cmp("t5_rst_dov", dov, 0);
        cmp("t5_rst_ready", {mr, dr}, 0);
        drive();
        step();
        step();
        reset = 1'b1;
        src_log.delete(); beat_log.delete();
        push(2, 88'h88, 1, 700);
        push(0, 88'h99, 1, 710);
        drive();
        drain("t5", 20);
        cmp_list("t5_src", src_log, '{0, 2});
        cmp_list("t5_beats", beat_log, '{710, 700});

`ifdef ADD_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) push(0, 88'h1, 2, 3000 + 10 * i);
        for (int i = 0; i < 2; i++) push(1, 88'h2, 2, 4000 + 10 * i);
        push(2, 88'h3, 2, 5000);
        drive();
        drain("t6", 80);
        cmp("t6_pkt_reth", pc_reth, 3);
        cmp("t6_pkt_aeth", pc_aeth, 2);
        cmp("t6_pkt_raw", pc_raw, 1);
        cmp("t6_beat_cnt", bc, 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
